kill_the_bit_core: RTL
======================

// Module: kill_the_bit_core
// PURPOSE
//  Parametrised game engine for Kill the Bit: a WIDTH-bit pattern rotates left at a programmable rate.
//  Each key press XORs its bit position: it kills a lit bit or spawns a new one.
//  Sits between the LED&KEY driver (debounced key levels in) and the LED/segment outputs.
//  Generalises the fixed 8-LED game with width, rate, start pattern, scoring and win/lose detection.
// PARAMETERS
//  WIDTH        8           pattern/LED/key width, >=2
//  TICK_CYCLES  50_000_000  clock cycles per rotation step, >=16
//  INIT_PATTERN 8'b0000_0001 pattern loaded on start, WIDTH bits, must be non-zero
//  SCORE_W      8           width of the kill and miss counters
// PORTS
//  i_clk     in   1        system clock
//  rst       in   1        synchronous reset, active-high
//  i_start   in   1        start/restart pulse, level sampled each cycle
//  i_keys    in   WIDTH    debounced key levels, 1 = pressed, synchronous to i_clk
//  o_leds    out  WIDTH    displayed pattern
//  o_state   out  2        0 IDLE, 1 PLAY, 2 WIN, 3 LOSE
//  o_score   out  SCORE_W  kills, saturating
//  o_misses  out  SCORE_W  spawns (press on an unlit bit), saturating
//  o_tick    out  1        one-cycle pulse on each rotation step
// BEHAVIOUR
//  Reset: state=IDLE, pattern=0, o_leds=0, o_score=0, o_misses=0, o_tick=0, tick counter=0, key_prev<=i_keys.
//    Loading key_prev from i_keys prevents keys held through reset from counting as presses.
//  Edge detect: press = i_keys & ~key_prev, registered each cycle. A press is acted on in the cycle it is detected.
//  Tick counter: counts 0..P-1, then wraps. o_tick=1 in the cycle it wraps.
//    Counts only in PLAY, WIN and LOSE; held at 0 in IDLE.
//  IDLE: o_leds=0. On i_start: pattern<=INIT_PATTERN, score<=0, misses<=0, counter<=0, next state PLAY.
//  PLAY: next pattern = (o_tick ? rotl(pattern,1) : pattern) ^ press.
//    When a tick and a press land in the same cycle, the XOR is applied to the rotated value.
//    Per pressed bit k, the bit under test is the post-rotation bit k:
//      bit was 1 -> score+1; bit was 0 -> misses+1.
//    Each counter increments by popcount of its matching presses, saturating at 2^SCORE_W-1.
//  Transitions are evaluated on the next pattern value:
//    next pattern == 0 -> WIN; next pattern all ones -> LOSE; otherwise stay in PLAY.
//  WIN: pattern frozen at 0. o_leds shows all-ones on odd tick phase, 0 on even (blinks at tick rate). Keys ignored.
//  LOSE: o_leds = all ones, steady. Keys ignored.
//  i_start in PLAY, WIN or LOSE restarts the game exactly as from IDLE, in the same cycle.
//    i_start takes priority over a same-cycle press or tick.
//  rst asserted mid-game: returns to IDLE next edge regardless of any other input.
//  Output latency: o_leds and o_state are registered and reflect an event one cycle after the edge that samples it.
//  Rotation wraps: bit WIDTH-1 moves to bit 0.
// CONFIGURATION
//  KILL_THE_BIT_SPEEDUP_EN defined:
//    level = min(score>>2, 3); period P = TICK_CYCLES >> level (x1, x2, x4, x8 speed).
//    A period change takes effect at the next counter wrap; a counter already >= new P wraps immediately.
//  KILL_THE_BIT_SPEEDUP_EN undefined: P = TICK_CYCLES fixed; no level logic is synthesised.
// TESTING (WIDTH=8, TICK_CYCLES=16, INIT_PATTERN=8'h01, SCORE_W=8)
//  T1: reset, then start pulse -> PLAY. o_leds goes 01,02,04..80,01 with o_tick every 16 cycles. Score and misses stay 0.
//  T2: with o_leds=04, press key 2 (no tick that cycle) -> next o_leds=00, score=1, state=WIN.
//    o_leds then blinks FF/00 on ticks.
//  T3: o_leds=01, press keys 1..7 together -> pattern FF, misses=7, state=LOSE, o_leds=FF steady.
//  T4: press key 1 in the same cycle as o_tick while o_leds=01 -> rotated 02^02=00, score=1, state=WIN.
//  T5: hold key 3 through reset and release -> no count. Start mid-game -> pattern=01 and counters cleared next cycle.
//  T6 (SPEEDUP_EN): after 4 kills o_tick period is 8 cycles; after 12 kills it is 2 cycles and stays at 2.
//    Without the macro the period remains 16 cycles.

Source files
------------

// File: rtl/kill_the_bit_core_if.sv
// Game-side bundle for kill_the_bit_core: start/key inputs from the LED&KEY driver,
// display, status and score outputs back to it.
interface kill_the_bit_core_if #(
   parameter int WIDTH   = 8,
   parameter int SCORE_W = 8
);
   logic               i_start;
   logic [WIDTH-1:0]   i_keys;
   logic [WIDTH-1:0]   o_leds;
   logic [1:0]         o_state;
   logic [SCORE_W-1:0] o_score;
   logic [SCORE_W-1:0] o_misses;
   logic               o_tick;

   modport master (
      output i_start, i_keys,
      input  o_leds, o_state, o_score, o_misses, o_tick
   );

   modport slave (
      input  i_start, i_keys,
      output o_leds, o_state, o_score, o_misses, o_tick
   );
endinterface

// File: rtl/kill_the_bit_core.sv
// Kill the Bit game engine: rotating WIDTH-bit pattern, key presses toggle bits, win/lose detection.
// Optional KILL_THE_BIT_SPEEDUP_EN: rotation period halves every 4 kills (up to x8).
module kill_the_bit_core #(
   parameter int               WIDTH        = 8,
   parameter int               TICK_CYCLES  = 50_000_000,
   parameter logic [WIDTH-1:0] INIT_PATTERN = WIDTH'(1),
   parameter int               SCORE_W      = 8
) (
   input logic               i_clk,
   input logic               rst,
   kill_the_bit_core_if.slave bus
);

   localparam int                 CNT_W     = $clog2(TICK_CYCLES);
   localparam int                 SUM_W     = SCORE_W + $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0]   ALL_ONES  = '1;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      WIN  = 2'd2,
      LOSE = 2'd3
   } state_t;

   state_t             state, state_n;
   logic [WIDTH-1:0]   pattern, pattern_n;
   logic [WIDTH-1:0]   key_prev, press, rotated;
   logic [WIDTH-1:0]   leds_q, leds_n;
   logic [SCORE_W-1:0] score, score_n;
   logic [SCORE_W-1:0] misses, misses_n;
   logic [CNT_W-1:0]   counter, counter_n, last;
   logic               phase, phase_n;
   logic               tick;

   function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] base,
                                                  input logic [WIDTH-1:0]   hits);
      logic [SUM_W-1:0] sum;
      sum = SUM_W'(base) + SUM_W'($countones(hits));
      if (sum > SUM_W'(SCORE_MAX))
         return SCORE_MAX;
      return sum[SCORE_W-1:0];
   endfunction

`ifdef KILL_THE_BIT_SPEEDUP_EN
   logic [1:0]  level;
   logic [31:0] period;

   // Speed level follows the kill count; comparing with >= lets a shortened period wrap at once
   always_comb begin
      if ({4'b0, score} >= (SCORE_W + 4)'(12))
         level = 2'd3;
      else if ({4'b0, score} >= (SCORE_W + 4)'(8))
         level = 2'd2;
      else if ({4'b0, score} >= (SCORE_W + 4)'(4))
         level = 2'd1;
      else
         level = 2'd0;
      period = 32'(TICK_CYCLES) >> level;
      last   = CNT_W'(period - 32'd1);
   end
`else
   assign last = CNT_W'(TICK_CYCLES - 1);
`endif

   assign press   = bus.i_keys & ~key_prev;
   assign tick    = (state != IDLE) && (counter >= last);
   assign rotated = tick ? {pattern[WIDTH-2:0], pattern[WIDTH-1]} : pattern;

   assign bus.o_leds   = leds_q;
   assign bus.o_state  = state;
   assign bus.o_score  = score;
   assign bus.o_misses = misses;
   assign bus.o_tick   = tick;

   // State register
   always_ff @(posedge i_clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   // Next-state and game datapath; start overrides any same-cycle tick or press
   always_comb begin
      state_n   = state;
      pattern_n = pattern;
      score_n   = score;
      misses_n  = misses;
      counter_n = counter;
      phase_n   = phase;
      if (bus.i_start) begin
         state_n   = PLAY;
         pattern_n = INIT_PATTERN;
         score_n   = '0;
         misses_n  = '0;
         counter_n = '0;
         phase_n   = 1'b0;
      end else if (state == IDLE) begin
         counter_n = '0;
      end else begin
         counter_n = tick ? '0 : counter + CNT_W'(1);
         phase_n   = phase ^ tick;
         if (state == PLAY) begin
            pattern_n = rotated ^ press;
            score_n   = sat_add(score, press & rotated);
            misses_n  = sat_add(misses, press & ~rotated);
            if (pattern_n == '0)
               state_n = WIN;
            else if (pattern_n == ALL_ONES)
               state_n = LOSE;
         end
      end
   end

   // Display for the state being entered, so o_leds is registered alongside o_state
   always_comb begin
      leds_n = '0;
      case (state_n)
         PLAY:    leds_n = pattern_n;
         WIN:     leds_n = phase_n ? ALL_ONES : '0;
         LOSE:    leds_n = ALL_ONES;
         default: leds_n = '0;
      endcase
   end

   // Datapath registers; key_prev follows the keys even in reset so held keys never count
   always_ff @(posedge i_clk) begin
      key_prev <= bus.i_keys;
      if (rst) begin
         pattern <= '0;
         score   <= '0;
         misses  <= '0;
         counter <= '0;
         phase   <= 1'b0;
         leds_q  <= '0;
      end else begin
         pattern <= pattern_n;
         score   <= score_n;
         misses  <= misses_n;
         counter <= counter_n;
         phase   <= phase_n;
         leds_q  <= leds_n;
      end
   end

endmodule
